// File: rtl/fb_sample_capture_if.sv
// Readout stream bundle for fb_sample_capture: valid/ready handshake
// carrying one signed sample per beat plus an end-of-readout marker.
interface fb_sample_capture_if #(
   parameter int DATA_W = 13
);
   logic                     rd_valid;
   logic                     rd_ready;
   logic                     rd_last;
   logic signed [DATA_W-1:0] rd_data;

   modport master (
      output rd_valid,
      output rd_data,
      output rd_last,
      input  rd_ready
   );

   modport slave (
      input  rd_valid,
      input  rd_data,
      input  rd_last,
      output rd_ready
   );
endinterface

// File: rtl/fb_sample_capture.sv
// Feedback sample capture: records a signed sample stream into an internal
// buffer during a store_strb window (after a programmable start offset),
// then drains the buffer over a valid/ready stream.
module fb_sample_capture #(
   parameter int DATA_W = 13,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     arm,
   input  logic                     store_strb,
   input  logic signed [9:0]        b1_strobe,
   input  logic signed [DATA_W-1:0] sample_in,
   fb_sample_capture_if.master      rd,
   output logic [ADDR_W:0]          count,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_DELAY   = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_READOUT = 3'd4;

   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   // Negative start offsets mean "start at the strobe edge".
   function automatic logic [9:0] clamp_offset(input logic signed [9:0] off);
      if (off[9])
         return 10'd0;
      return $unsigned(off);
   endfunction

   logic [2:0]               r_state;
   logic                     r_strb_p1;
   logic [9:0]               r_dcnt;
   logic [ADDR_W:0]          r_waddr;
   logic [ADDR_W-1:0]        r_rptr;
   logic [ADDR_W:0]          r_count;
   logic                     r_overflow;
   logic                     r_done;
   logic                     r_rd_valid;
   logic                     r_rd_last;
   logic signed [DATA_W-1:0] r_rd_data;
   logic signed [DATA_W-1:0] r_mem [DEPTH];

   logic                     w_rise;
   logic [9:0]               w_off;
   logic                     w_we;
   logic [ADDR_W-1:0]        w_wa;
   logic                     w_hs;
   logic [ADDR_W:0]          w_last_idx;
   logic                     w_rd_load;
   logic [ADDR_W-1:0]        w_rd_addr;
   logic                     w_rd_last_nxt;

   assign w_rise        = store_strb & ~r_strb_p1;
   assign w_off         = clamp_offset(b1_strobe);
   assign w_hs          = r_rd_valid & rd.rd_ready;
   assign w_last_idx    = r_count - CNT_ONE;
   assign w_wa          = r_waddr[ADDR_W-1:0];
   assign w_rd_last_nxt = ({1'b0, w_rd_addr} == w_last_idx);

   // Buffer write enable: first sample at offset 0 (from ARMED or DELAY), then every strobe-high cycle.
   always_comb begin
      w_we = 1'b0;
      case (r_state)
         S_ARMED:   w_we = w_rise && (w_off == 10'd0);
         S_DELAY:   w_we = store_strb && (r_dcnt == 10'd0);
         S_CAPTURE: w_we = store_strb;
         default:   w_we = 1'b0;
      endcase
   end

   // Readout fetch: first word on READOUT entry, next word on each non-final handshake; stalls re-use the held word.
   always_comb begin
      w_rd_load = 1'b0;
      w_rd_addr = r_rptr;
      if (r_state == S_READOUT) begin
         if (!r_rd_valid) begin
            w_rd_load = 1'b1;
         end else if (w_hs && !r_rd_last) begin
            w_rd_load = 1'b1;
            w_rd_addr = r_rptr + PTR_ONE;
         end
      end
   end

   // Control FSM: arming, start-offset delay, capture window, readout handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_strb_p1  <= 1'b0;
         r_dcnt     <= '0;
         r_waddr    <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
      end else begin
         r_strb_p1 <= store_strb;
         r_done    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  r_state    <= S_ARMED;
                  r_overflow <= 1'b0;
                  r_count    <= '0;
                  r_waddr    <= '0;
               end
            end
            S_ARMED: begin
               if (w_rise) begin
                  if (w_off == 10'd0) begin
                     r_waddr <= CNT_ONE;
                     r_state <= S_CAPTURE;
                  end else begin
                     // Counter reaches 0 on the cycle whose sample is the first one kept.
                     r_dcnt  <= w_off - 10'd1;
                     r_state <= S_DELAY;
                  end
               end
            end
            S_DELAY: begin
               if (!store_strb) begin
                  r_done  <= 1'b1;
                  r_count <= '0;
                  r_state <= S_IDLE;
               end else if (r_dcnt == 10'd0) begin
                  r_waddr <= CNT_ONE;
                  r_state <= S_CAPTURE;
               end else begin
                  r_dcnt <= r_dcnt - 10'd1;
               end
            end
            S_CAPTURE: begin
               if (!store_strb) begin
                  r_done  <= 1'b1;
                  r_count <= r_waddr;
                  r_rptr  <= '0;
                  r_state <= (r_waddr != '0) ? S_READOUT : S_IDLE;
               end else if (r_waddr == CNT_LAST) begin
                  // This write fills the buffer while the window is still open.
                  r_waddr    <= CNT_FULL;
                  r_overflow <= 1'b1;
                  r_done     <= 1'b1;
                  r_count    <= CNT_FULL;
                  r_rptr     <= '0;
                  r_state    <= S_READOUT;
               end else begin
                  r_waddr <= r_waddr + CNT_ONE;
               end
            end
            S_READOUT: begin
               if (w_rd_load) begin
                  r_rd_valid <= 1'b1;
                  r_rd_last  <= w_rd_last_nxt;
                  r_rptr     <= w_rd_addr;
               end else if (w_hs) begin
                  r_rd_valid <= 1'b0;
                  r_rd_last  <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Buffer RAM write port; contents are never cleared.
   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[w_wa] <= sample_in;
   end

   // Registered RAM read into the output data register, held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_rd_data <= '0;
      else if (w_rd_load)
         r_rd_data <= r_mem[w_rd_addr];
   end

   assign rd.rd_valid = r_rd_valid;
   assign rd.rd_data  = r_rd_data;
   assign rd.rd_last  = r_rd_last;
   assign count       = r_count;
   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_fb_sample_capture.sv
// Directed bench for fb_sample_capture: capture windows with offsets,
// clamp, empty window, overflow, backpressured readout, ignore rules, reset.
module tb_fb_sample_capture;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              arm;
   logic              store_strb;
   logic signed [9:0] b1_strobe;
   logic signed [12:0] sample_in;
   logic [10:0]       count;
   logic              busy;
   logic              done;
   logic              overflow;

   fb_sample_capture_if #(.DATA_W(13)) rd_if ();

   fb_sample_capture #(.DATA_W(13), .ADDR_W(10), .DEPTH(1024)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm        (arm),
      .store_strb (store_strb),
      .b1_strobe  (b1_strobe),
      .sample_in  (sample_in),
      .rd         (rd_if),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int n_done  = 0;
   int cyc     = 0;
   logic [15:0] lfsr = 16'hACE1;
   logic signed [12:0] wq[$];
   logic signed [12:0] eq[$];

   always @(negedge clk) if (done === 1'b1) n_done++;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   function automatic logic signed [12:0] sample_val(input int kind, input int i);
      if (kind == 0) return 13'(i - 4);
      if (kind == 1) return 13'(cyc % 4096);
      return $signed(lfsr[12:0]);
   endfunction

   // Drives a window of len high cycles, then one low (fall) cycle.
   task automatic run_window(input int off, input int len, input int kind, input int arm_at);
      logic signed [12:0] v;
      b1_strobe = off[9:0];
      wq.delete();
      for (int i = 0; i < len; i++) begin
         v = sample_val(kind, i);
         store_strb = 1'b1;
         sample_in  = v;
         wq.push_back(v);
         if (i == arm_at) arm = 1'b1;
         step();
         arm = 1'b0;
      end
      store_strb = 1'b0;
      sample_in  = 13'sh0AA;
      step();
   endtask

   task automatic build_exp(input int off, input int len);
      int lo;
      int hi;
      lo = (off < 0) ? 0 : off;
      hi = len;
      if (hi > lo + 1024) hi = lo + 1024;
      eq.delete();
      for (int i = lo; i < hi; i++) eq.push_back(wq[i]);
   endtask

   task automatic read_out(input int n, input bit rnd, input bit strb_poke);
      int k = 0;
      bit stalled = 1'b0;
      logic signed [12:0] held = '0;
      logic rdy;
      for (int c = 0; c < 4000 && k < n; c++) begin
         rdy = rnd ? lfsr[3] : 1'b1;
         if (strb_poke) store_strb = (c >= 3 && c < 20);
         rd_if.rd_ready = rdy;
         if (stalled) begin
            chk("stall_valid", rd_if.rd_valid, 1);
            chk("stall_data", $signed(rd_if.rd_data), held);
            stalled = 1'b0;
         end
         if (rd_if.rd_valid) begin
            if (rdy) begin
               chk("rd_data", $signed(rd_if.rd_data), eq[k]);
               chk("rd_last", rd_if.rd_last, (k == n - 1) ? 1 : 0);
               k++;
            end else begin
               held    = rd_if.rd_data;
               stalled = 1'b1;
            end
         end
         step();
      end
      store_strb     = 1'b0;
      rd_if.rd_ready = 1'b0;
      chk("rd_words", k, n);
      chk("rd_valid_after", rd_if.rd_valid, 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      int d0;
      bit seen;
      rst_n = 1'b0; arm = 1'b0; store_strb = 1'b0; b1_strobe = '0;
      sample_in = '0; rd_if.rd_ready = 1'b0;
      repeat (3) step();
      chk("rst_valid", rd_if.rd_valid, 0);
      chk("rst_last", rd_if.rd_last, 0);
      chk("rst_data", rd_if.rd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_count", count, 0);
      rst_n = 1'b1;
      step();

      // basic window, ramp -4..3
      do_arm();
      chk("arm_busy", busy, 1);
      chk("arm_count", count, 0);
      d0 = n_done;
      run_window(0, 8, 0, -1);
      step();
      chk("basic_done", n_done - d0, 1);
      chk("basic_count", count, 8);
      build_exp(0, 8);
      chk("basic_first_exp", eq[0], -4);
      read_out(8, 1'b0, 1'b0);
      chk("basic_ovf", overflow, 0);

      // start offset 25 over a 328-cycle window
      do_arm();
      run_window(25, 328, 1, -1);
      step();
      chk("off_count", count, 303);
      build_exp(25, 328);
      read_out(303, 1'b0, 1'b0);

      // negative offset clamps to 0
      do_arm();
      run_window(-3, 5, 0, -1);
      step();
      chk("clamp_count", count, 5);
      build_exp(-3, 5);
      read_out(5, 1'b0, 1'b0);

      // offset longer than the window: empty capture
      do_arm();
      d0 = n_done;
      run_window(20, 5, 0, -1);
      step();
      chk("empty_done", n_done - d0, 1);
      chk("empty_count", count, 0);
      chk("empty_busy", busy, 0);
      seen = 1'b0;
      repeat (6) begin
         if (rd_if.rd_valid) seen = 1'b1;
         step();
      end
      chk("empty_no_valid", seen, 0);

      // overflow: 1500-cycle window
      do_arm();
      d0 = n_done;
      run_window(0, 1500, 1, -1);
      step();
      chk("ovf_done", n_done - d0, 1);
      chk("ovf_count", count, 1024);
      chk("ovf_flag", overflow, 1);
      build_exp(0, 1500);
      read_out(1024, 1'b0, 1'b0);
      chk("ovf_sticky", overflow, 1);
      do_arm();
      chk("ovf_cleared", overflow, 0);

      // backpressure, plus a window during readout that must be ignored
      run_window(0, 64, 2, -1);
      step();
      chk("bp_count", count, 64);
      build_exp(0, 64);
      d0 = n_done;
      read_out(64, 1'b1, 1'b1);
      repeat (3) step();
      chk("bp_no_done", n_done - d0, 0);
      chk("bp_count_kept", count, 64);
      chk("bp_idle", busy, 0);

      // arm during capture is ignored
      do_arm();
      d0 = n_done;
      run_window(0, 10, 0, 3);
      step();
      chk("armcap_done", n_done - d0, 1);
      chk("armcap_count", count, 10);
      build_exp(0, 10);
      read_out(10, 1'b0, 1'b0);

      // asynchronous reset mid-capture
      do_arm();
      b1_strobe = '0;
      for (int i = 0; i < 10; i++) begin
         store_strb = 1'b1;
         sample_in  = 13'(100 + i);
         step();
      end
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", rd_if.rd_valid, 0);
      chk("mrst_last", rd_if.rd_last, 0);
      chk("mrst_data", rd_if.rd_data, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_ovf", overflow, 0);
      chk("mrst_count", count, 0);
      store_strb = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // normal operation after reset
      do_arm();
      run_window(0, 3, 0, -1);
      step();
      chk("post_rst_count", count, 3);
      build_exp(0, 3);
      read_out(3, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
